// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU and its multiplexed hex display.
// Optional build macro honoured by the display driver: LEADING_ZERO_BLANK_EN.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_NOT = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Active-low common-anode segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex scanner: prescaled digit rotation, nibble lookup and
// optional leading-zero blanking when LEADING_ZERO_BLANK_EN is defined.
module seg_scan_driver
  import alu_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 50000,
  parameter int NIBBLES_W   = DIGITS * 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NIBBLES_W-1:0] value,
  output logic [6:0]           seg,
  output logic [DIGITS-1:0]    digit_en
);

  localparam int PS_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PAD_W = DIGITS * 4;

  logic [PS_W-1:0]  prescaler;
  logic [IDX_W-1:0] digit_idx;
  logic [PAD_W-1:0] padded;
  logic [3:0]       nibble;
  logic             blank;

  assign padded = PAD_W'(value);

  // Dwell counter and digit rotation
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      digit_idx <= '0;
    end else if (prescaler == PS_W'(REFRESH_DIV - 1)) begin
      prescaler <= '0;
      if (digit_idx == IDX_W'(DIGITS - 1)) begin
        digit_idx <= '0;
      end else begin
        digit_idx <= digit_idx + IDX_W'(1);
      end
    end else begin
      prescaler <= prescaler + PS_W'(1);
    end
  end

  // Digit select and segment decode for the digit currently scanned
  always_comb begin
    nibble   = padded[{digit_idx, 2'b00} +: 4];
    digit_en = ~(DIGITS'(1) << digit_idx);
`ifdef LEADING_ZERO_BLANK_EN
    // Digit 0 always shows so that a zero result reads as a single "0"
    blank = (digit_idx != '0) && ((padded >> {digit_idx, 2'b00}) == '0);
`else
    blank = 1'b0;
`endif
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = hex_to_seg(nibble);
    end
  end

endmodule

// File: rtl/alu_seq_display.sv
// Sequential ALU (capture -> execute -> done) with registered result/flags,
// driving a multiplexed hex display. Optional macro: LEADING_ZERO_BLANK_EN.
module alu_seq_display
  import alu_pkg::*;
#(
  parameter int N           = 4,
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      firstNum,
  input  logic [N-1:0]      secNum,
  input  logic [2:0]        opSel,
  input  logic              execute,
  output logic [N-1:0]      result,
  output logic [3:0]        flags,
  output logic              busy,
  output logic              done,
  output logic [6:0]        segOutput,
  output logic [DIGITS-1:0] digitEnable
);

  localparam logic [N:0] N_VAL = (N + 1)'(N);

  state_t         state, state_next;
  logic           exec_prev;
  logic           exec_rise;
  logic [N-1:0]   op_a, op_b;
  opcode_t        op;
  logic [N:0]     wide;
  logic [N-1:0]   alu_res;
  logic           alu_c, alu_v;

  assign exec_rise = execute & ~exec_prev;

  // ALU datapath on the captured operands
  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        wide    = {1'b0, op_a} + {1'b0, op_b};
        alu_res = wide[N-1:0];
        alu_c   = wide[N];
        alu_v   = (op_a[N-1] == op_b[N-1]) && (alu_res[N-1] != op_a[N-1]);
      end
      OP_SUB: begin
        wide    = {1'b0, op_a} + {1'b0, ~op_b} + (N + 1)'(1);
        alu_res = wide[N-1:0];
        alu_c   = wide[N];
        alu_v   = (op_a[N-1] != op_b[N-1]) && (alu_res[N-1] != op_a[N-1]);
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      // The extra bit in 'wide' catches the last bit shifted out
      OP_SHL: begin
        if ({1'b0, op_b} >= N_VAL) begin
          alu_res = '0;
        end else begin
          wide    = {1'b0, op_a} << op_b;
          alu_res = wide[N-1:0];
          alu_c   = wide[N];
        end
      end
      OP_SHR: begin
        if ({1'b0, op_b} >= N_VAL) begin
          alu_res = '0;
        end else begin
          wide    = {op_a, 1'b0} >> op_b;
          alu_res = wide[N:1];
          alu_c   = wide[0];
        end
      end
      OP_NOT: alu_res = ~op_a;
      default: alu_res = '0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (exec_rise) begin
          state_next = ST_EXEC;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_EXEC: state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, operand capture and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      exec_prev <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op        <= OP_ADD;
      result    <= '0;
      flags     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      exec_prev <= execute;
      busy      <= (state_next == ST_EXEC);
      done      <= (state_next == ST_DONE);
      if (state == ST_IDLE && exec_rise) begin
        op_a <= firstNum;
        op_b <= secNum;
        op   <= opcode_t'(opSel);
      end
      if (state == ST_EXEC) begin
        result         <= alu_res;
        flags[FLAG_N]  <= alu_res[N-1];
        flags[FLAG_Z]  <= (alu_res == '0);
        flags[FLAG_C]  <= alu_c;
        flags[FLAG_V]  <= alu_v;
      end
    end
  end

  seg_scan_driver #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .NIBBLES_W   (N)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .value    (result),
    .seg      (segOutput),
    .digit_en (digitEnable)
  );

endmodule

// File: tb/tb_alu_seq_display.sv
// Self-checking bench for alu_seq_display (N=4, DIGITS=2, REFRESH_DIV=4):
// directed vector table, random ops against an arithmetic model, scan and corner sequences.
module tb_alu_seq_display;

  localparam int N   = 4;
  localparam int DG  = 2;
  localparam int RD  = 4;
  localparam int MOD = 1 << N;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  firstNum, secNum;
  logic [2:0]    opSel;
  logic          execute;
  logic [N-1:0]  result;
  logic [3:0]    flags;
  logic          busy, done;
  logic [6:0]    segOutput;
  logic [DG-1:0] digitEnable;

  int total = 0;
  int bad   = 0;

  alu_seq_display #(.N(N), .DIGITS(DG), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .firstNum(firstNum), .secNum(secNum), .opSel(opSel),
    .execute(execute), .result(result), .flags(flags), .busy(busy), .done(done),
    .segOutput(segOutput), .digitEnable(digitEnable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] res;
    logic [3:0] flg;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic definitions; returns {result, N, Z, C, V}
  function automatic logic [7:0] model(input int a, input int b, input int op);
    int r, c, v, sa, sb, s;
    r = 0; c = 0; v = 0;
    sa = (a >= MOD / 2) ? a - MOD : a;
    sb = (b >= MOD / 2) ? b - MOD : b;
    case (op)
      0: begin s = a + b; r = s % MOD; c = (s >= MOD); v = (sa + sb < -MOD / 2) || (sa + sb >= MOD / 2); end
      1: begin s = a + (MOD - 1 - b) + 1; r = s % MOD; c = (s >= MOD); v = (sa - sb < -MOD / 2) || (sa - sb >= MOD / 2); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: if (b < N) begin r = (a * (1 << b)) % MOD; c = (b > 0) ? ((a >> (N - b)) & 1) : 0; end
      6: if (b < N) begin r = a >> b; c = (b > 0) ? ((a >> (b - 1)) & 1) : 0; end
      default: r = (MOD - 1) - a;
    endcase
    return {4'(r), (r >= MOD / 2) ? 1'b1 : 1'b0, (r == 0) ? 1'b1 : 1'b0, 1'(c), 1'(v)};
  endfunction

  // One execute pulse with the latency and handshake checked along the way
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic [3:0] exp_res, input logic [3:0] exp_flg, input string name);
    firstNum = a; secNum = b; opSel = op; execute = 1'b1;
    tick();
    execute = 1'b0;
    check({name, ".busy"}, 16'(busy), 16'd1);
    check({name, ".done_early"}, 16'(done), 16'd0);
    tick();
    check({name, ".done"}, 16'(done), 16'd1);
    check({name, ".result"}, 16'(result), 16'(exp_res));
    check({name, ".flags"}, 16'(flags), 16'(exp_flg));
    tick();
    check({name, ".done_clear"}, 16'(done), 16'd0);
  endtask

  vec_t vecs [11];
  logic [7:0] m;
  int dones;
  logic [3:0] ra, rb;
  logic [2:0] rop;
  logic found;
  logic [DG-1:0] prev_en;
  logic [6:0] digit1_seg;

  initial begin
    vecs[0]  = '{4'h7, 4'h1, 3'd0, 4'h8, 4'b1001};
    vecs[1]  = '{4'h3, 4'h3, 3'd1, 4'h0, 4'b0110};
    vecs[2]  = '{4'h2, 4'h5, 3'd1, 4'hD, 4'b1000};
    vecs[3]  = '{4'h9, 4'h1, 3'd5, 4'h2, 4'b0010};
    vecs[4]  = '{4'hF, 4'h4, 3'd6, 4'h0, 4'b0100};
    vecs[5]  = '{4'hF, 4'h5, 3'd2, 4'h5, 4'b0000};
    vecs[6]  = '{4'h8, 4'h1, 3'd3, 4'h9, 4'b1000};
    vecs[7]  = '{4'h5, 4'h5, 3'd4, 4'h0, 4'b0100};
    vecs[8]  = '{4'h5, 4'h0, 3'd7, 4'hA, 4'b1000};
    vecs[9]  = '{4'hF, 4'h1, 3'd0, 4'h0, 4'b0110};
    vecs[10] = '{4'h8, 4'h1, 3'd1, 4'h7, 4'b0011};

    rst = 1'b1; firstNum = '0; secNum = '0; opSel = '0; execute = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset.result", 16'(result), 16'd0);
    check("reset.flags", 16'(flags), 16'd0);
    check("reset.seg", 16'(segOutput), 16'(7'b1000000));
    check("reset.en", 16'(digitEnable), 16'(2'b10));
    check("reset.busy", 16'(busy), 16'd0);
    check("reset.done", 16'(done), 16'd0);

    // Reset while in EXEC discards the operation
    firstNum = 4'h7; secNum = 4'h7; opSel = 3'd0; execute = 1'b1;
    tick();
    execute = 1'b0;
    check("rstmid.busy", 16'(busy), 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) dones++;
      tick();
    end
    check("rstmid.dones", 16'(dones), 16'd0);
    check("rstmid.result", 16'(result), 16'd0);
    check("rstmid.busy_after", 16'(busy), 16'd0);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flg, $sformatf("vec%0d", i));
      m = model(int'(vecs[i].a), int'(vecs[i].b), int'(vecs[i].op));
      check($sformatf("vec%0d.model", i), 16'(m), 16'({vecs[i].res, vecs[i].flg}));
    end

    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rop = 3'($urandom_range(0, 7));
      m = model(int'(ra), int'(rb), int'(rop));
      run_op(ra, rb, rop, m[7:4], m[3:0], $sformatf("rnd%0d", i));
    end

    // Held-high execute triggers exactly once
    firstNum = 4'h1; secNum = 4'h2; opSel = 3'd0; execute = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) dones++;
    end
    execute = 1'b0;
    tick();
    check("held.dones", 16'(dones), 16'd1);
    check("held.result", 16'(result), 16'h3);

    // Edges during EXEC/DONE ignored; operand changes after capture ignored
    firstNum = 4'h1; secNum = 4'h1; opSel = 3'd0; execute = 1'b1;
    tick();
    execute = 1'b0; firstNum = 4'h5; secNum = 4'h5;
    tick();
    execute = 1'b1;
    dones = 0;
    if (done) dones++;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dones++;
    end
    execute = 1'b0;
    tick();
    check("ignore.dones", 16'(dones), 16'd1);
    check("ignore.result", 16'(result), 16'h2);

    // Scan of result 4'hA
    run_op(4'hA, 4'hF, 3'd2, 4'hA, 4'b1000, "scan_load");
`ifdef LEADING_ZERO_BLANK_EN
    digit1_seg = 7'b1111111;
`else
    digit1_seg = 7'b1000000;
`endif
    found = 1'b0;
    prev_en = digitEnable;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (prev_en == 2'b01 && digitEnable == 2'b10) found = 1'b1;
      else prev_en = digitEnable;
    end
    check("scan.found", 16'(found), 16'd1);
    for (int i = 0; i < RD; i++) begin
      check($sformatf("scan.d0en%0d", i), 16'(digitEnable), 16'(2'b10));
      check($sformatf("scan.d0seg%0d", i), 16'(segOutput), 16'(7'b0001000));
      tick();
    end
    for (int i = 0; i < RD; i++) begin
      check($sformatf("scan.d1en%0d", i), 16'(digitEnable), 16'(2'b01));
      check($sformatf("scan.d1seg%0d", i), 16'(segOutput), 16'(digit1_seg));
      tick();
    end
    check("scan.wrap_en", 16'(digitEnable), 16'(2'b10));
    check("scan.wrap_seg", 16'(segOutput), 16'(7'b0001000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
